// File: rtl/board_pkg.sv
// Shared types and helpers for the parametrised game board and its undo history.
package board_pkg;

  localparam int MAX_CELL_W = 3;  // enough for up to 7 players plus the empty code

  typedef logic [MAX_CELL_W-1:0] cell_t;

  localparam cell_t EMPTY = '0;

  typedef enum logic [0:0] {
    S_PLAY = 1'b0,
    S_FULL = 1'b1
  } state_e;

  function automatic int cell_w_f(input int num_players);
    return $clog2(num_players + 1);
  endfunction

  function automatic int loc_w_f(input int ncell);
    return $clog2(ncell + 1);
  endfunction

  function automatic cell_t player_to_cell(input cell_t p);
    return p + cell_t'(1);
  endfunction

endpackage

// File: rtl/board_grid_move_stack.sv
// LIFO of accepted move locations; top entry is readable in the same cycle it is popped.
module move_stack #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] ptr_m1;
  logic             do_push, do_pop;

  assign ptr_m1  = ptr_q - 1'b1;
  assign empty_o = (ptr_q == '0);
  assign top_o   = mem_q[ptr_m1[IDX_W-1:0]];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !pop_i && (ptr_q != DEPTH_L);

  always_comb begin
    ptr_d = ptr_q;
    if (do_pop) begin
      ptr_d = ptr_m1;
    end else if (do_push) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[ptr_q[IDX_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/board_grid.sv
// N x N board of cell owners with round-robin turn tracking and placement arbitration.
// Optional undo history is enabled by defining BOARD_GRID_UNDO_EN.
module board_grid
  import board_pkg::*;
#(
  parameter int BOARD_DIM   = 5,
  parameter int NUM_PLAYERS = 2,
  parameter int CELL_W      = cell_w_f(NUM_PLAYERS),
  parameter int LOC_W       = loc_w_f(BOARD_DIM * BOARD_DIM)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clr,
  input  logic                                  place,
`ifdef BOARD_GRID_UNDO_EN
  input  logic                                  undo,
`endif
  input  logic [LOC_W-1:0]                      loc,
  output logic [BOARD_DIM*BOARD_DIM*CELL_W-1:0] board,
  output logic [CELL_W-1:0]                     cur_player,
  output logic [NUM_PLAYERS-1:0]                turn_onehot,
  output logic                                  place_ack,
  output logic                                  place_err,
  output logic [LOC_W-1:0]                      move_count,
  output logic                                  board_full
);

  localparam int NCELL = BOARD_DIM * BOARD_DIM;
  localparam logic [LOC_W-1:0]  NCELL_L  = LOC_W'(NCELL);
  localparam logic [CELL_W-1:0] LAST_PLY = CELL_W'(NUM_PLAYERS - 1);

  logic [CELL_W-1:0] cells_q [NCELL];
  logic [CELL_W-1:0] cells_d [NCELL];
  logic [CELL_W-1:0] cur_q, cur_d;
  logic [LOC_W-1:0]  count_q, count_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  state_e            state_q, state_d;

  logic [NCELL-1:0]  loc_hit;
  logic [NCELL-1:0]  occ;
  logic              loc_ok, occupied, accept;
  logic [CELL_W-1:0] next_ply, prev_ply;
  cell_t             cur_cell;

  genvar gi;
  generate
    for (gi = 0; gi < NCELL; gi++) begin : g_cell
      assign loc_hit[gi] = (loc == LOC_W'(gi + 1));
      assign occ[gi]     = (cells_q[gi] != '0);
      assign board[gi*CELL_W +: CELL_W] = cells_q[gi];
    end
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_turn
      assign turn_onehot[gi] = (cur_q == CELL_W'(gi));
    end
  endgenerate

  assign loc_ok   = (loc != '0) && (loc <= NCELL_L);
  assign occupied = |(loc_hit & occ);
  assign accept   = place && (state_q == S_PLAY) && loc_ok && !occupied;
  assign next_ply = (cur_q == LAST_PLY) ? '0 : cur_q + 1'b1;
  assign prev_ply = (cur_q == '0) ? LAST_PLY : cur_q - 1'b1;
  assign cur_cell = player_to_cell(cell_t'(cur_q));

`ifdef BOARD_GRID_UNDO_EN
  logic [LOC_W-1:0] hist_top;
  logic             hist_empty;
  logic             undo_go;
  logic [NCELL-1:0] top_hit;

  generate
    for (gi = 0; gi < NCELL; gi++) begin : g_undo_hit
      assign top_hit[gi] = (hist_top == LOC_W'(gi + 1));
    end
  endgenerate

  assign undo_go = undo && !hist_empty;

  move_stack #(
    .WIDTH (LOC_W),
    .DEPTH (NCELL)
  ) u_move_stack (
    .clk     (clk),
    .rst     (rst || clr),
    .push_i  (accept && !undo),
    .pop_i   (undo_go),
    .data_i  (loc),
    .top_o   (hist_top),
    .empty_o (hist_empty)
  );
`endif

  always_comb begin
    cells_d = cells_q;
    cur_d   = cur_q;
    count_d = count_q;
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
`ifdef BOARD_GRID_UNDO_EN
    // Undo takes precedence; a simultaneous place is silently dropped.
    if (undo) begin
      if (undo_go) begin
        for (int i = 0; i < NCELL; i++) begin
          if (top_hit[i]) cells_d[i] = '0;
        end
        count_d = count_q - 1'b1;
        cur_d   = prev_ply;
        state_d = S_PLAY;
        ack_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else
`endif
    if (place) begin
      if (accept) begin
        for (int i = 0; i < NCELL; i++) begin
          if (loc_hit[i]) cells_d[i] = cur_cell[CELL_W-1:0];
        end
        count_d = count_q + 1'b1;
        cur_d   = next_ply;
        ack_d   = 1'b1;
        if (count_q == NCELL_L - 1'b1) state_d = S_FULL;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < NCELL; i++) cells_q[i] <= '0;
      cur_q   <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= S_PLAY;
    end else begin
      cells_q <= cells_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign cur_player = cur_q;
  assign move_count = count_q;
  assign place_ack  = ack_q;
  assign place_err  = err_q;
  assign board_full = (state_q == S_FULL);

endmodule

// File: tb/tb_board_grid.sv
// Randomised bench for board_grid against a rule-level model; covers undo when BOARD_GRID_UNDO_EN is set.
module tb_board_grid;

  localparam int NC = 25;
  localparam int CW = 2;
  localparam int LW = 5;
  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst, clr, place, undo;
  logic [LW-1:0]    loc;
  logic [NC*CW-1:0] board;
  logic [CW-1:0]    cur_player;
  logic [NP-1:0]    turn_onehot;
  logic             place_ack, place_err, board_full;
  logic [LW-1:0]    move_count;

  logic             place3;
  logic [LW-1:0]    loc3;
  logic [NC*CW-1:0] board3;
  logic [CW-1:0]    cur3;
  logic [2:0]       onehot3;
  logic             ack3, err3, full3;
  logic [LW-1:0]    count3;

  board_grid #(.BOARD_DIM(5), .NUM_PLAYERS(2)) dut (
    .clk(clk), .rst(rst), .clr(clr), .place(place),
`ifdef BOARD_GRID_UNDO_EN
    .undo(undo),
`endif
    .loc(loc), .board(board), .cur_player(cur_player), .turn_onehot(turn_onehot),
    .place_ack(place_ack), .place_err(place_err), .move_count(move_count),
    .board_full(board_full)
  );

  board_grid #(.BOARD_DIM(5), .NUM_PLAYERS(3)) dut3 (
    .clk(clk), .rst(rst), .clr(1'b0), .place(place3),
`ifdef BOARD_GRID_UNDO_EN
    .undo(1'b0),
`endif
    .loc(loc3), .board(board3), .cur_player(cur3), .turn_onehot(onehot3),
    .place_ack(ack3), .place_err(err3), .move_count(count3),
    .board_full(full3)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Reference model: plain arrays and a queue for the move history
  int m_cells[NC];
  int m_cur, m_count;
  bit m_full, m_ack, m_err;
  int m_hist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_cells[k] = 0;
    m_cur = 0; m_count = 0; m_full = 0; m_ack = 0; m_err = 0;
    m_hist.delete();
  endtask

  function automatic logic [NC*CW-1:0] model_board();
    logic [NC*CW-1:0] b;
    int v;
    b = '0;
    for (int k = 0; k < NC; k++) begin
      v = m_cells[k];
      b[k*CW +: CW] = v[CW-1:0];
    end
    return b;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "/board"}, 64'(board), 64'(model_board()));
    check({tag, "/cur"},   64'(cur_player), 64'(m_cur));
    check({tag, "/count"}, 64'(move_count), 64'(m_count));
    check({tag, "/ack"},   64'(place_ack), 64'(m_ack));
    check({tag, "/err"},   64'(place_err), 64'(m_err));
    check({tag, "/full"},  64'(board_full), 64'(m_full));
    check({tag, "/onehot"}, 64'(turn_onehot), 64'(1) << m_cur);
  endtask

  task automatic step(input string tag, input bit p, input int l, input bit u, input bit c);
    place = p; loc = LW'(l); clr = c;
`ifdef BOARD_GRID_UNDO_EN
    undo = u;
`endif
    @(posedge clk); #1;
    m_ack = 0; m_err = 0;
    if (c) begin
      model_reset();
`ifdef BOARD_GRID_UNDO_EN
    end else if (u) begin
      if (m_count > 0) begin
        m_cells[m_hist.pop_back() - 1] = 0;
        m_count--;
        m_cur = (m_cur + NP - 1) % NP;
        m_full = 0;
        m_ack = 1;
      end else begin
        m_err = 1;
      end
`endif
    end else if (p) begin
      if (!m_full && l >= 1 && l <= NC && m_cells[l-1] == 0) begin
        m_cells[l-1] = m_cur + 1;
        m_hist.push_back(l);
        m_count++;
        m_cur = (m_cur + 1) % NP;
        m_full = (m_count == NC);
        m_ack = 1;
      end else begin
        m_err = 1;
      end
    end
    n_txn++;
    $display("txn %0d %s place=%0d loc=%0d undo=%0d clr=%0d -> ack=%0d err=%0d cur=%0d count=%0d full=%0d",
             n_txn, tag, p, l, u, c, place_ack, place_err, cur_player, move_count, board_full);
    check_all(tag);
  endtask

  initial begin
    int perm[NC];
    int tmp, j;
    int locs3[4];
    int exp3[4];

    rst = 1'b1; clr = 1'b0; place = 1'b0; undo = 1'b0; loc = '0;
    place3 = 1'b0; loc3 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_all("reset");

    // Two placements alternate players
    step("p1", 1, 1, 0, 0);
    step("p2", 1, 2, 0, 0);
    check("cell1", 64'(board[0 +: CW]), 64'd1);
    check("cell2", 64'(board[CW +: CW]), 64'd2);

    // Rejections: occupied, zero, above NCELL, unused code
    step("occ", 1, 1, 0, 0);
    step("loc0", 1, 0, 0, 0);
    step("loc26", 1, 26, 0, 0);
    step("loc31", 1, 31, 0, 0);
    step("idle", 0, 3, 0, 0);

    // Fill every cell in shuffled order, then probe the full state
    step("clr", 0, 0, 0, 1);
    for (int k = 0; k < NC; k++) perm[k] = k + 1;
    for (int k = NC - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
    end
    for (int k = 0; k < NC; k++) step("fill", 1, perm[k], 0, 0);
    check("full_after_25", 64'(board_full), 64'd1);
    step("place_full", 1, perm[0], 0, 0);
    step("bad_full", 1, 0, 0, 0);
    step("clr_full", 0, 0, 0, 1);

    // Held place on the same cell: ack then err
    step("hold1", 1, 9, 0, 0);
    step("hold2", 1, 9, 0, 0);

`ifdef BOARD_GRID_UNDO_EN
    step("u_clr", 0, 0, 0, 1);
    step("u_p7", 1, 7, 0, 0);
    step("u_p13", 1, 13, 0, 0);
    step("u_undo", 0, 0, 1, 0);
    check("u_cell13", 64'(board[12*CW +: CW]), 64'd0);
    check("u_count", 64'(move_count), 64'd1);
    check("u_cur", 64'(cur_player), 64'd1);
    step("u_both", 1, 5, 1, 0);
    check("u_cell5", 64'(board[4*CW +: CW]), 64'd0);
    step("u_empty", 0, 0, 1, 0);
    // Undo out of the full state
    for (int k = 0; k < NC; k++) step("u_fill", 1, perm[k], 0, 0);
    step("u_unfull", 0, 0, 1, 0);
    step("u_refill", 1, perm[NC-1], 0, 0);
`endif

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      bit p, u, c;
      int l;
      p = ($urandom_range(0, 3) != 0);
      l = $urandom_range(0, 31);
      u = 1'b0;
`ifdef BOARD_GRID_UNDO_EN
      u = ($urandom_range(0, 6) == 0);
`endif
      c = ($urandom_range(0, 79) == 0);
      step("rnd", p, l, u, c);
    end

    // Three-player instance
    locs3 = '{3, 9, 17, 25};
    exp3  = '{1, 2, 3, 1};
    for (int k = 0; k < 4; k++) begin
      place3 = 1'b1; loc3 = LW'(locs3[k]);
      @(posedge clk); #1;
      n_txn++;
      $display("txn %0d p3 loc=%0d -> ack=%0d err=%0d cur=%0d", n_txn, locs3[k], ack3, err3, cur3);
      check("p3_ack", 64'(ack3), 64'd1);
    end
    place3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("p3_cell", 64'(board3[(locs3[k]-1)*CW +: CW]), 64'(exp3[k]));
    end
    check("p3_cur", 64'(cur3), 64'd1);
    check("p3_onehot", 64'(onehot3), 64'd2);
    check("p3_count", 64'(count3), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
